multichannel_moving_avg_filter: RTL and testbench

MULTICHANNEL_MOVING_AVG_FILTER -- requirements
Module: multichannel_moving_avg_filter

---
 rtl/multichannel_moving_avg_filter_if.sv | 37 +++
 rtl/multichannel_moving_avg_filter.sv | 183 ++++++++++++++++++
 tb/tb_multichannel_moving_avg_filter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multichannel_moving_avg_filter_if.sv
// Sample/result bundle for the multichannel moving-average filter.
// MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN adds the OUT_FULL result flag.
interface multichannel_moving_avg_filter_if #(
    parameter int DATA_BITS    = 32,
    parameter int DELAY_BITS   = 4,
    parameter int CHANNEL_BITS = 2
);
    logic                    READY;
    logic                    IN_VALID;
    logic [CHANNEL_BITS-1:0] IN_CHANNEL;
    logic [DELAY_BITS-1:0]   DELAY;
    logic [DATA_BITS-1:0]    IN_VALUE;
    logic                    OUT_VALID;
    logic [CHANNEL_BITS-1:0] OUT_CHANNEL;
    logic [DATA_BITS-1:0]    OUT_VALUE;
`ifdef MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN
    logic                    OUT_FULL;

    modport master (
        output IN_VALID, IN_CHANNEL, DELAY, IN_VALUE,
        input  READY, OUT_VALID, OUT_CHANNEL, OUT_VALUE, OUT_FULL
    );
    modport slave (
        input  IN_VALID, IN_CHANNEL, DELAY, IN_VALUE,
        output READY, OUT_VALID, OUT_CHANNEL, OUT_VALUE, OUT_FULL
    );
`else
    modport master (
        output IN_VALID, IN_CHANNEL, DELAY, IN_VALUE,
        input  READY, OUT_VALID, OUT_CHANNEL, OUT_VALUE
    );
    modport slave (
        input  IN_VALID, IN_CHANNEL, DELAY, IN_VALUE,
        output READY, OUT_VALID, OUT_CHANNEL, OUT_VALUE
    );
`endif
endinterface

// File: rtl/multichannel_moving_avg_filter.sv
// Per-channel difference of a running sum against its value (DELAY+1) samples back.
// Optional fill flag: define MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN.
module multichannel_moving_avg_filter #(
    parameter int DATA_BITS    = 32,
    parameter int DELAY_BITS   = 4,
    parameter int CHANNEL_BITS = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLEAR,
    multichannel_moving_avg_filter_if.slave filt
);
    localparam int NUM_CH    = 1 << CHANNEL_BITS;
    localparam int ADDR_BITS = CHANNEL_BITS + DELAY_BITS;
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0]  ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [DELAY_BITS-1:0] PTR_ONE   = DELAY_BITS'(1);

    typedef enum logic {CLEARING = 1'b0, RUN = 1'b1} state_t;

    state_t                  r_state, w_state_next;
    logic [ADDR_BITS-1:0]    r_clr_addr, w_clr_addr_next;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_mem_we;
    logic [ADDR_BITS-1:0]    w_mem_waddr;
    logic [ADDR_BITS-1:0]    w_mem_raddr;
    logic [DATA_BITS-1:0]    w_mem_wdata;
    logic [DATA_BITS-1:0]    r_mem [DEPTH];
    logic [DATA_BITS-1:0]    r_rd_data;
    logic [DELAY_BITS-1:0]   w_wp [NUM_CH];
    logic [DELAY_BITS-1:0]   w_wp_sel;
    logic [DELAY_BITS-1:0]   w_rd_ptr;

    logic                    r_s1_valid;
    logic [CHANNEL_BITS-1:0] r_s1_channel;
    logic [DATA_BITS-1:0]    r_s1_value;
    logic                    r_out_valid;
    logic [CHANNEL_BITS-1:0] r_out_channel;
    logic [DATA_BITS-1:0]    r_out_value;

    // A sample coinciding with CLEAR is dropped so the clear sees a quiet history.
    assign w_accept = filt.IN_VALID && w_ready && !CLEAR;
    assign w_wp_sel = w_wp[filt.IN_CHANNEL];
    assign w_rd_ptr = w_wp_sel - filt.DELAY - PTR_ONE;
    assign w_mem_raddr = {filt.IN_CHANNEL, w_rd_ptr};

`ifdef MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN
    localparam logic [DELAY_BITS:0] FILL_MAX = {1'b1, {DELAY_BITS{1'b0}}};
    localparam logic [DELAY_BITS:0] FILL_ONE = {{DELAY_BITS{1'b0}}, 1'b1};
    logic [DELAY_BITS:0]     w_fill [NUM_CH];
    logic                    w_full_sel;
    logic                    r_s1_full;
    logic                    r_out_full;

    assign w_full_sel = (w_fill[filt.IN_CHANNEL] >= ({1'b0, filt.DELAY} + FILL_ONE));
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DELAY_BITS-1:0] r_wp;
            always_ff @(posedge CLK) begin
                if (RESET || CLEAR) begin
                    r_wp <= '0;
                end else if (w_accept && filt.IN_CHANNEL == CHANNEL_BITS'(gi)) begin
                    r_wp <= r_wp + PTR_ONE;
                end
            end
            assign w_wp[gi] = r_wp;
`ifdef MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN
            logic [DELAY_BITS:0] r_fill;
            always_ff @(posedge CLK) begin
                if (RESET || CLEAR) begin
                    r_fill <= '0;
                end else if (w_accept && filt.IN_CHANNEL == CHANNEL_BITS'(gi)
                             && r_fill != FILL_MAX) begin
                    r_fill <= r_fill + FILL_ONE;
                end
            end
            assign w_fill[gi] = r_fill;
`endif
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= CLEARING;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // The clear sweep and live samples share the single RAM write port.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_ready         = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_waddr     = r_clr_addr;
        w_mem_wdata     = '0;
        case (r_state)
            CLEARING: begin
                w_mem_we        = 1'b1;
                w_clr_addr_next = r_clr_addr + ADDR_ONE;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = {filt.IN_CHANNEL, w_wp_sel};
                    w_mem_wdata = filt.IN_VALUE;
                end
            end
            default: begin
                w_state_next = CLEARING;
            end
        endcase
        if (CLEAR) begin
            w_state_next    = CLEARING;
            w_clr_addr_next = '0;
        end
    end

    // Read-first RAM: a read of the entry being written returns its old contents.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        r_rd_data <= r_mem[w_mem_raddr];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_valid    <= 1'b0;
            r_s1_channel  <= '0;
            r_s1_value    <= '0;
            r_out_valid   <= 1'b0;
            r_out_channel <= '0;
            r_out_value   <= '0;
        end else begin
            r_s1_valid  <= w_accept;
            r_out_valid <= r_s1_valid && !CLEAR;
            if (w_accept) begin
                r_s1_channel <= filt.IN_CHANNEL;
                r_s1_value   <= filt.IN_VALUE;
            end
            if (r_s1_valid && !CLEAR) begin
                r_out_channel <= r_s1_channel;
                r_out_value   <= r_s1_value - r_rd_data;
            end
        end
    end

`ifdef MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_full  <= 1'b0;
            r_out_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_full <= w_full_sel;
            end
            if (r_s1_valid && !CLEAR) begin
                r_out_full <= r_s1_full;
            end
        end
    end
    assign filt.OUT_FULL = r_out_full;
`endif

    assign filt.READY       = w_ready;
    assign filt.OUT_VALID   = r_out_valid;
    assign filt.OUT_CHANNEL = r_out_channel;
    assign filt.OUT_VALUE   = r_out_value;

endmodule

// File: tb/tb_multichannel_moving_avg_filter.sv
// Directed bench for the multichannel moving-average filter with a result scoreboard.
// Honours MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN when checking OUT_FULL.
module tb_multichannel_moving_avg_filter;
    logic CLK = 1'b0;
    logic RESET;
    logic CLEAR;

    always #5 CLK = ~CLK;

    multichannel_moving_avg_filter_if #(
        .DATA_BITS(32), .DELAY_BITS(4), .CHANNEL_BITS(2)
    ) bus ();

    multichannel_moving_avg_filter #(
        .DATA_BITS(32), .DELAY_BITS(4), .CHANNEL_BITS(2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .CLEAR (CLEAR),
        .filt  (bus)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] val;
        logic        full;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hist [4][256];
    int          n_hist [4];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the delayed value is simply the (DELAY+1)-th previous sample, or 0.
    task automatic model_push(input int ch, input logic [31:0] v, input int d);
        exp_t e;
        int   n;
        n      = n_hist[ch];
        e.ch   = 2'(ch);
        e.val  = v - ((n >= d + 1) ? hist[ch][n-d-1] : 32'd0);
        e.full = (n >= d + 1);
        e.due  = cyc + 2;
        hist[ch][n] = v;
        n_hist[ch]  = n + 1;
        sb.push_back(e);
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) n_hist[c] = 0;
    endtask

    task automatic send(input int ch, input logic [31:0] v, input int d);
        bus.IN_VALID   = 1'b1;
        bus.IN_CHANNEL = 2'(ch);
        bus.DELAY      = 4'(d);
        bus.IN_VALUE   = v;
        model_push(ch, v, d);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (bus.READY !== 1'b1 && cnt < 200) begin
            // A strobe while not ready must leave no trace.
            if (cnt == 10) begin
                bus.IN_VALID   = 1'b1;
                bus.IN_CHANNEL = 2'd0;
                bus.IN_VALUE   = 32'h0000DEAD;
            end else begin
                bus.IN_VALID = 1'b0;
            end
            cnt++;
            @(negedge CLK);
        end
        bus.IN_VALID = 1'b0;
        check(tag, 64'(cnt), 64'd64);
    endtask

    task automatic do_clear(input bit discard);
        if (discard) void'(sb.pop_back());
        CLEAR          = 1'b1;
        bus.IN_VALID   = 1'b1;
        bus.IN_CHANNEL = 2'd0;
        bus.IN_VALUE   = 32'h00000BAD;
        @(negedge CLK);
        CLEAR        = 1'b0;
        bus.IN_VALID = 1'b0;
        model_clear();
    endtask

    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    check("result_due", 64'(cyc), 64'(sb[0].due));
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    $display("result cyc=%0d ch=%0d value=%08h exp=%08h",
                             cyc, bus.OUT_CHANNEL, bus.OUT_VALUE, sb[0].val);
                    check("out_valid", 64'(bus.OUT_VALID), 64'd1);
                    check("out_channel", 64'(bus.OUT_CHANNEL), 64'(sb[0].ch));
                    check("out_value", 64'(bus.OUT_VALUE), 64'(sb[0].val));
`ifdef MULTICHANNEL_MOVING_AVG_FILTER_FILL_FLAG_EN
                    check("out_full", 64'(bus.OUT_FULL), 64'(sb[0].full));
`endif
                    void'(sb.pop_front());
                end else begin
                    check("no_strobe", 64'(bus.OUT_VALID), 64'd0);
                end
            end
        end
    endtask

    initial begin
        RESET          = 1'b1;
        CLEAR          = 1'b0;
        bus.IN_VALID   = 1'b0;
        bus.IN_CHANNEL = '0;
        bus.DELAY      = '0;
        bus.IN_VALUE   = '0;
        model_clear();
        fork
            monitor();
        join_none

        // Reset for one cycle and check idle outputs.
        @(negedge CLK);
        RESET  = 1'b0;
        mon_en = 1'b1;
        check("reset_ready", 64'(bus.READY), 64'd0);
        check("reset_out_valid", 64'(bus.OUT_VALID), 64'd0);
        check("reset_out_channel", 64'(bus.OUT_CHANNEL), 64'd0);
        check("reset_out_value", 64'(bus.OUT_VALUE), 64'd0);
        wait_ready("reset_ready_low_cycles");

        // Channel 0, window of 4.
        for (int k = 1; k <= 8; k++) send(0, 32'(10 * k), 3);
        repeat (3) @(negedge CLK);

        // Signed wrap without saturation.
        send(1, 32'h7FFFFFF0, 0);
        send(1, 32'h80000010, 0);
        repeat (3) @(negedge CLK);

        // Full-depth window on channel 2.
        for (int k = 1; k <= 20; k++) send(2, 32'(k), 15);
        repeat (3) @(negedge CLK);

        // Clear with two samples in flight; the younger one is discarded.
        send(0, 32'd900, 3);
        send(0, 32'd901, 3);
        do_clear(1'b1);
        check("clear_ready", 64'(bus.READY), 64'd0);
        wait_ready("clear_ready_low_cycles");
        send(0, 32'd555, 5);
        repeat (3) @(negedge CLK);

        // Interleaved channels from a fresh history, DELAY=0.
        do_clear(1'b0);
        wait_ready("clear2_ready_low_cycles");
        for (int k = 1; k <= 6; k++) begin
            send(0, 32'(100 * k), 0);
            send(3, 32'(7 * k), 0);
        end
        // Window change on channel 3 keeps its history.
        send(3, 32'd49, 2);
        send(3, 32'd56, 15);
        repeat (3) @(negedge CLK);

        // Reset mid-stream discards the pipeline.
        send(2, 32'd1000, 0);
        send(2, 32'd2000, 0);
        void'(sb.pop_back());
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_clear();
        check("midreset_out_valid", 64'(bus.OUT_VALID), 64'd0);
        check("midreset_out_value", 64'(bus.OUT_VALUE), 64'd0);
        check("midreset_out_channel", 64'(bus.OUT_CHANNEL), 64'd0);
        wait_ready("midreset_ready_low_cycles");
        send(2, 32'd77, 1);
        repeat (5) @(negedge CLK);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
